mem_line_responder: RTL and testbench
=====================================

Name: mem_line_responder

Overview:
Lower-memory side of the cache line-fill / write-back interface. It serves whole-line refill reads and dirty-line write-backs issued by cache lines on a miss or eviction. Each line is BLOCK_SIZE words of WORD_SIZE*8 bits, moved one word per beat over a valid/ready handshake. It holds a MEM_LINES-entry line store, and adds a programmable read latency to model main memory.

Parameters:
ADDRESS_WORD_SIZE, 32, request address width
BLOCK_SIZE, 16, words per line (beats per burst); power of two
WORD_SIZE, 4, bytes per word; beat width = WORD_SIZE*8 = 32
MEM_LINES, 64, lines held in the store; power of two
LATENCY, 4, idle cycles between read accept and first read beat; 0 is legal

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_write  in  1  1 = write-back, 0 = line fill
req_addr  in  ADDRESS_WORD_SIZE  line address; low log2(BLOCK_SIZE*WORD_SIZE) bits ignored
wb_data  in  32  write-back beat data
wb_valid  in  1  write-back beat present
wb_ready  out  1  write-back beat accepted when wb_valid & wb_ready
wb_done  out  1  one-cycle pulse when the write-back is committed
rsp_data  out  32  read beat data
rsp_valid  out  1  read beat present
rsp_ready  in  1  read beat consumed when rsp_valid & rsp_ready
rsp_last  out  1  high with the final (BLOCK_SIZE-1) beat
rsp_err  out  1  address-range error (see Optional Feature)

Behaviour:
- Clocking and reset: single clock clk. rst_b is asynchronous and active-low.
- Reset:
  - FSM goes to IDLE; beat and latency counters clear.
  - Output values: req_ready=1, wb_ready=0, wb_done=0, rsp_valid=0, rsp_last=0, rsp_data=0, rsp_err=0.
  - Line store contents are NOT reset; they persist across rst_b. This includes reset asserted mid-burst: a partially written line keeps the beats already committed.
- Address split: line index = req_addr[log2(MEM_LINES)+5 : 6] (default [11:6]). The index is latched on accept. Word offset bits [5:2] are ignored; bursts always start at beat 0.
- FSM states: IDLE, WAIT, RD_BURST, WR_BURST, ACK.
- IDLE:
  - req_ready=1 (combinational from state).
  - On accept with req_write=0: go to WAIT (or RD_BURST if LATENCY=0), latency counter = 0.
  - On accept with req_write=1: go to WR_BURST.
- WAIT: counts LATENCY cycles, then RD_BURST. The first rsp_valid is therefore seen LATENCY+1 cycles after the accept edge.
- RD_BURST:
  - rsp_valid=1; rsp_data = store[index][beat].
  - beat advances only on rsp_valid & rsp_ready. rsp_data, rsp_last and beat are held stable while stalled.
  - rsp_last=1 exactly when beat==BLOCK_SIZE-1.
  - Handshake of the last beat: go to IDLE, clear beat. rsp_valid=0 in the next cycle.
- WR_BURST:
  - wb_ready=1.
  - Each wb_valid & wb_ready writes wb_data to store[index][beat] on that edge, then beat increments.
  - After beat BLOCK_SIZE-1: go to ACK.
- ACK: wb_done=1 for one cycle, then IDLE.
- Out-of-state inputs:
  - req_ready=0 outside IDLE; req_valid there is not accepted, and the requester must hold it.
  - wb_valid outside WR_BURST is ignored.
  - rsp_ready with rsp_valid=0 has no effect.
- Beat counter: log2(BLOCK_SIZE) bits; wraps to 0 at end of burst.
- Read-after-write: a read issued after wb_done returns the newly written data.

Optional Feature:
Macro ADDR_CHECK_EN.
- Defined: a request is out of range if any req_addr bit above the index field is nonzero.
  - Out-of-range read: follows normal timing, but every beat has rsp_data=0 and rsp_err=1.
  - Out-of-range write-back: beats are consumed and discarded, and wb_done pulses with rsp_err=1 in the same cycle.
  - The store is never modified by an out-of-range request.
- Undefined: upper address bits are ignored, so addresses alias modulo MEM_LINES lines. rsp_err is tied to 0.

Decomposition:
- Shared package mem_if_pkg:
  - FSM state enum.
  - Beat width constant (32).
  - Line-offset width (6).
  - Beat-counter width.
  - Index-width function of MEM_LINES.
- Sub-module mem_line_store: synchronous-write / combinational-read word array.
  - Depth MEM_LINES*BLOCK_SIZE, addressed by {index, beat}.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
  - No reset.

Test Plan:
1. Hold rst_b=0 for 3 cycles -> req_ready=1, rsp_valid=0, wb_ready=0, wb_done=0, rsp_data=0.
2. Write-back to 0x00000140 (line 5), wb_valid held high, beats 0x05000000+i for i=0..15 -> wb_ready high 16 cycles, then wb_done high exactly 1 cycle, then req_ready=1.
3. Read 0x00000140, LATENCY=4, rsp_ready=1 -> rsp_valid rises 5 cycles after accept. Beats are 0x05000000..0x0500000F in order, rsp_last only on 0x0500000F, then rsp_valid=0.
4. Same read with rsp_ready alternating 1,0 -> each beat held stable while stalled, 16 beats over 32 cycles, none dropped or repeated.
5. Pulse req_valid mid-burst -> not accepted. Assert rst_b=0 at read beat 7 -> rsp_valid=0 immediately. After release, re-read of line 5 returns the intact pattern from step 2.
6. Read 0x00010140:
   - With ADDR_CHECK_EN: 16 zero beats, each with rsp_err=1.
   - Without ADDR_CHECK_EN: the step-2 pattern of line 5 is returned, rsp_err=0.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and constants for the cache line-fill / write-back memory side.
package mem_if_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_BURST,
        WR_BURST,
        ACK
    } mem_state_t;

    localparam int unsigned BEAT_W     = 32;
    localparam int unsigned LINE_OFF_W = 6;
    localparam int unsigned BEAT_CNT_W = 4;

    function automatic int unsigned index_w(input int unsigned mem_lines);
        return (mem_lines > 1) ? $clog2(mem_lines) : 1;
    endfunction

endpackage

// File: rtl/mem_line_store.sv
// Word array backing the line store: synchronous write, combinational read, no reset.
module mem_line_store #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_line_responder.sv
// Lower-memory responder for whole-line refills and dirty-line write-backs.
// Optional macro ADDR_CHECK_EN flags requests whose address lies above the store.
module mem_line_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDRESS_WORD_SIZE = 32,
    parameter int unsigned BLOCK_SIZE        = 16,
    parameter int unsigned WORD_SIZE         = 4,
    parameter int unsigned MEM_LINES         = 64,
    parameter int unsigned LATENCY           = 4
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDRESS_WORD_SIZE-1:0] req_addr,
    input  logic [BEAT_W-1:0]            wb_data,
    input  logic                         wb_valid,
    output logic                         wb_ready,
    output logic                         wb_done,
    output logic [BEAT_W-1:0]            rsp_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_last,
    output logic                         rsp_err
);

    localparam int unsigned OFF_W = $clog2(BLOCK_SIZE * WORD_SIZE);
    localparam int unsigned IDX_W = index_w(MEM_LINES);
    localparam int unsigned CNT_W = $clog2(BLOCK_SIZE);
    localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    mem_state_t             state_q, state_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   oor_q, oor_d;
    logic                   req_oor;
    logic                   store_we;
    logic [BEAT_W-1:0]      store_rdata;
    logic                   addr_unused;

    assign addr_unused = ^{req_addr[OFF_W-1:0], req_addr[ADDRESS_WORD_SIZE-1:OFF_W+IDX_W]};

`ifdef ADDR_CHECK_EN
    assign req_oor = |req_addr[ADDRESS_WORD_SIZE-1:OFF_W+IDX_W];
`else
    assign req_oor = 1'b0;
`endif

    mem_line_store #(
        .DEPTH  (MEM_LINES * BLOCK_SIZE),
        .ADDR_W (IDX_W + CNT_W),
        .DATA_W (BEAT_W)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr ({idx_q, beat_q}),
        .wdata (wb_data),
        .raddr ({idx_q, beat_q}),
        .rdata (store_rdata)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        idx_d     = idx_q;
        oor_d     = oor_q;
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        wb_done   = 1'b0;
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        store_we  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    idx_d  = req_addr[OFF_W +: IDX_W];
                    oor_d  = req_oor;
                    lat_d  = '0;
                    beat_d = '0;
                    if (req_write) begin
                        state_d = WR_BURST;
                    end else if (LATENCY == 0) begin
                        state_d = RD_BURST;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = RD_BURST;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RD_BURST: begin
                rsp_valid = 1'b1;
                rsp_last  = (beat_q == LAST_BEAT);
                rsp_data  = oor_q ? '0 : store_rdata;
                rsp_err   = oor_q;
                if (rsp_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WR_BURST: begin
                wb_ready = 1'b1;
                if (wb_valid) begin
                    // out-of-range bursts are drained without touching the store
                    store_we = !oor_q;
                    beat_d   = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                wb_done = 1'b1;
                rsp_err = oor_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: directed line-5 scenarios plus randomized bursts against a line-array model.
module tb_mem_line_responder;

    localparam int LAT = 4;

`ifdef ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_done;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_last;
    logic        rsp_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [64][16];
    bit          written [64];
    logic [31:0] wdat    [16];

    always #5 clk = ~clk;

    mem_line_responder #(
        .ADDRESS_WORD_SIZE (32),
        .BLOCK_SIZE        (16),
        .WORD_SIZE         (4),
        .MEM_LINES         (64),
        .LATENCY           (LAT)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .wb_data   (wb_data),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_done   (wb_done),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err)
    );

    function automatic bit is_oor(input logic [31:0] a);
        return ADDR_CHECK && ((a >> 12) != 0);
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 6) % 64);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_line(input logic [31:0] addr, input bit stall);
        int sent;
        int cyc;
        int ln;
        bit oor;
        bit v;
        oor = is_oor(addr);
        ln  = line_of(addr);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        chk("wr_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        sent = 0;
        cyc  = 0;
        while (sent < 16 && cyc < 200) begin
            chk("wr_ready", wb_ready, 1);
            chk("wr_done_early", wb_done, 0);
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wb_valid = v;
            wb_data  = v ? wdat[sent] : $urandom();
            @(negedge clk);
            cyc++;
            if (v) sent++;
        end
        wb_valid = 1'b0;
        chk("wr_beats", sent, 16);
        chk("wr_done", wb_done, 1);
        chk("wr_done_err", rsp_err, oor);
        chk("wr_ack_ready", wb_ready, 0);
        @(negedge clk);
        chk("wr_done_pulse", wb_done, 0);
        chk("wr_idle_req_ready", req_ready, 1);
        if (!stall) chk("wr_cycles", cyc, 16);
        if (!oor) begin
            for (int i = 0; i < 16; i++) ref_mem[ln][i] = wdat[i];
            written[ln] = 1'b1;
        end
    endtask

    // mode: 0 = always ready, 1 = ready alternating starting low, 2 = random ready
    task automatic rd_line(input logic [31:0] addr, input int mode, input int abort_beat, input bit pulse);
        int b;
        int cyc;
        int waitc;
        int ln;
        bit oor;
        bit r;
        oor = is_oor(addr);
        ln  = line_of(addr);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        rsp_ready = 1'b0;
        chk("rd_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        waitc = 0;
        while (rsp_valid !== 1'b1 && waitc < 50) begin
            chk("rd_wait_req_ready", req_ready, 0);
            @(negedge clk);
            waitc++;
        end
        chk("rd_latency", waitc, LAT);
        b   = 0;
        cyc = 0;
        while (b < 16 && cyc < 200) begin
            chk("rd_valid", rsp_valid, 1);
            chk("rd_data", rsp_data, oor ? 32'h0 : ref_mem[ln][b]);
            chk("rd_last", rsp_last, b == 15);
            chk("rd_err", rsp_err, oor);
            if (b == abort_beat) begin
                rst_b     = 1'b0;
                req_valid = 1'b0;
                rsp_ready = 1'b0;
                #1;
                chk("abort_valid", rsp_valid, 0);
                chk("abort_req_ready", req_ready, 1);
                repeat (2) @(negedge clk);
                rst_b = 1'b1;
                @(negedge clk);
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = cyc[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            rsp_ready = r;
            if (pulse) begin
                req_valid = (cyc == 3);
                req_write = 1'b1;
                req_addr  = 32'h0000_0080;
                if (cyc == 3) chk("busy_req_ready", req_ready, 0);
            end
            @(negedge clk);
            cyc++;
            if (r) b++;
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        chk("rd_beats", b, 16);
        chk("rd_done_valid", rsp_valid, 0);
        chk("rd_done_req_ready", req_ready, 1);
        if (mode == 1) chk("rd_alt_cycles", cyc, 32);
    endtask

    initial begin
        logic [31:0] addr;
        int ln;
        rst_b     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        wb_data   = '0;
        wb_valid  = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_wb_done", wb_done, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst_b = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) wdat[i] = 32'h0500_0000 + 32'(i);
        wr_line(32'h0000_0140, 1'b0);

        // stray write beats while not in a write burst must not reach the store
        wb_valid = 1'b1;
        wb_data  = 32'hDEAD_BEEF;
        rd_line(32'h0000_0140, 0, -1, 1'b0);
        wb_valid = 1'b0;

        rd_line(32'h0000_0140, 1, -1, 1'b0);
        rd_line(32'h0000_0140, 0, 7, 1'b1);
        rd_line(32'h0000_0140, 0, -1, 1'b0);
        rd_line(32'h0001_0140, 2, -1, 1'b0);

        repeat (12) begin
            ln   = $urandom_range(0, 63);
            addr = ($urandom_range(0, 1) == 1) ? ($urandom() & 32'hFFFF_F000) : 32'h0;
            addr = addr | (32'(ln) << 6) | ($urandom() & 32'h3F);
            for (int i = 0; i < 16; i++) wdat[i] = $urandom();
            wr_line(addr, 1'($urandom_range(0, 1)));
        end

        repeat (20) begin
            ln = $urandom_range(0, 63);
            while (!written[ln]) ln = $urandom_range(0, 63);
            addr = ($urandom_range(0, 2) == 0) ? ($urandom() & 32'hFFFF_F000) : 32'h0;
            addr = addr | (32'(ln) << 6) | ($urandom() & 32'h3F);
            rd_line(addr, 2, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
